hex_seg_decoder: RTL and testbench

HEX_SEG_DECODER -- requirements
Module: hex_seg_decoder

---
 rtl/plotfour_pkg.sv | 22 ++
 rtl/seg7_lookup.sv | 39 +++
 rtl/hex_seg_decoder.sv | 85 ++++++++
 tb/tb_hex_seg_decoder.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/plotfour_pkg.sv
// plotfour_pkg: shared seven-segment constants and decoder FSM encoding.
// Contents: SEG_0..SEG_F active-low glyph codes, SEG_BLANK all-off code, state_t.
package plotfour_pkg;
  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_A     = 7'h08;
  localparam logic [6:0] SEG_B     = 7'h03;
  localparam logic [6:0] SEG_C     = 7'h46;
  localparam logic [6:0] SEG_D     = 7'h21;
  localparam logic [6:0] SEG_E     = 7'h06;
  localparam logic [6:0] SEG_F     = 7'h0E;
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  typedef enum logic [1:0] {ST_WAIT, ST_SETTLE, ST_LOCKED} state_t;
endpackage

// File: rtl/seg7_lookup.sv
// seg7_lookup: combinational active-low seven-segment pattern to hex digit lookup.
// Ports: seg[6:0] pattern in; digit[3:0] decoded value, legal (one of 16 glyphs), is_blank (all-off).
module seg7_lookup
  import plotfour_pkg::*;
(
  input  logic [6:0] seg,
  output logic [3:0] digit,
  output logic       legal,
  output logic       is_blank
);
  always_comb begin
    digit = 4'h0;
    legal = 1'b1;
    is_blank = 1'b0;
    case (seg)
      SEG_0: digit = 4'h0;
      SEG_1: digit = 4'h1;
      SEG_2: digit = 4'h2;
      SEG_3: digit = 4'h3;
      SEG_4: digit = 4'h4;
      SEG_5: digit = 4'h5;
      SEG_6: digit = 4'h6;
      SEG_7: digit = 4'h7;
      SEG_8: digit = 4'h8;
      SEG_9: digit = 4'h9;
      SEG_A: digit = 4'hA;
      SEG_B: digit = 4'hB;
      SEG_C: digit = 4'hC;
      SEG_D: digit = 4'hD;
      SEG_E: digit = 4'hE;
      SEG_F: digit = 4'hF;
      SEG_BLANK: begin
        legal = 1'b0;
        is_blank = 1'b1;
      end
      default: legal = 1'b0;
    endcase
  end
endmodule

// File: rtl/hex_seg_decoder.sv
// hex_seg_decoder: debounces a sampled seven-segment pattern and decodes it to a hex digit.
// Ports: clk, resetn (sync, active-low), seg_in[6:0], sample_en;
//        value[3:0], valid, blank, new_value (pulse), err (pulse), err_count[7:0] (saturating).
module hex_seg_decoder
  import plotfour_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic [6:0] seg_in,
  input  logic       sample_en,
  output logic [3:0] value,
  output logic       valid,
  output logic       blank,
  output logic       new_value,
  output logic       err,
  output logic [7:0] err_count
);
  state_t     r_state, w_state_nx;
  logic [6:0] r_sample;
  logic [3:0] r_cnt, w_cnt_nx;
  logic [3:0] w_digit, w_value_nx;
  logic       w_legal, w_is_blank, w_new, w_count, w_accept;
  logic       w_valid_nx, w_blank_nx, w_new_nx, w_err_nx;
  logic [7:0] w_errc_nx;

  seg7_lookup u_lookup (
    .seg      (seg_in),
    .digit    (w_digit),
    .legal    (w_legal),
    .is_blank (w_is_blank)
  );

  // WAIT forces the first enabled sample after reset to count as new, even 7F
  assign w_new    = sample_en && (r_state == ST_WAIT || seg_in != r_sample);
  assign w_count  = w_new || (sample_en && r_state == ST_SETTLE);
  assign w_cnt_nx = w_new ? 4'd1 : r_cnt + 4'd1;
  assign w_accept = w_count && (w_cnt_nx == 4'(STABLE_CYCLES));

  always_ff @(posedge clk)
    if (!resetn) r_state <= ST_WAIT;
    else r_state <= w_state_nx;

  always_comb w_state_nx = w_accept ? ST_LOCKED : w_new ? ST_SETTLE : r_state;

  always_comb begin
    w_value_nx = value;
    w_valid_nx = w_new ? 1'b0 : valid;
    w_blank_nx = w_new ? 1'b0 : blank;
    w_new_nx = 1'b0;
    w_err_nx = 1'b0;
    w_errc_nx = err_count;
    if (w_accept) begin
      w_valid_nx = w_legal;
      w_blank_nx = w_is_blank;
      w_new_nx = w_legal;
      w_err_nx = !w_legal && !w_is_blank;
      w_value_nx = w_legal ? w_digit : value;
      w_errc_nx = (w_err_nx && err_count != 8'hFF) ? err_count + 8'd1 : err_count;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_sample <= SEG_BLANK;
      r_cnt <= 4'd0;
      value <= 4'h0;
      valid <= 1'b0;
      blank <= 1'b0;
      new_value <= 1'b0;
      err <= 1'b0;
      err_count <= 8'd0;
    end else begin
      if (w_new) r_sample <= seg_in;
      if (w_count) r_cnt <= w_cnt_nx;
      value <= w_value_nx;
      valid <= w_valid_nx;
      blank <= w_blank_nx;
      new_value <= w_new_nx;
      err <= w_err_nx;
      err_count <= w_errc_nx;
    end
  end
endmodule

// File: tb/tb_hex_seg_decoder.sv
// tb_hex_seg_decoder: directed vector table plus randomized run against a behavioural model.
module tb_hex_seg_decoder;
  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       sample_en = 1'b0;
  logic [6:0] seg_in = 7'h7F;
  logic [3:0] v4, v1;
  logic       vl4, vl1, bl4, bl1, nv4, nv1, er4, er1;
  logic [7:0] ec4, ec1;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  hex_seg_decoder #(.STABLE_CYCLES(4)) u4 (
    .clk(clk), .resetn(resetn), .seg_in(seg_in), .sample_en(sample_en),
    .value(v4), .valid(vl4), .blank(bl4), .new_value(nv4), .err(er4), .err_count(ec4)
  );
  hex_seg_decoder #(.STABLE_CYCLES(1)) u1 (
    .clk(clk), .resetn(resetn), .seg_in(seg_in), .sample_en(sample_en),
    .value(v1), .valid(vl1), .blank(bl1), .new_value(nv1), .err(er1), .err_count(ec1)
  );

  logic [6:0] codes [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                             7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  typedef struct {
    logic [6:0] last;
    int run;
    bit fresh;
    int value;
    bit valid, blank, nv, err;
    int errc;
  } m_t;
  m_t m4, m1;

  // A pattern is accepted on the n-th consecutive identical enabled sample.
  function automatic m_t step(m_t m, bit rst_n, bit en, logic [6:0] seg, int n);
    int idx;
    if (!rst_n) begin
      m.last = 7'h7F; m.run = 0; m.fresh = 1; m.value = 0;
      m.valid = 0; m.blank = 0; m.nv = 0; m.err = 0; m.errc = 0;
      return m;
    end
    m.nv = 0;
    m.err = 0;
    if (!en) return m;
    if (m.fresh || seg != m.last) begin
      m.fresh = 0; m.last = seg; m.run = 1; m.valid = 0; m.blank = 0;
    end else if (m.run < 1000) m.run++;
    if (m.run == n) begin
      idx = -1;
      for (int i = 0; i < 16; i++) if (codes[i] == seg) idx = i;
      if (idx >= 0) begin
        m.value = idx; m.valid = 1; m.nv = 1;
      end else if (seg == 7'h7F) m.blank = 1;
      else begin
        m.err = 1;
        m.errc = (m.errc < 255) ? m.errc + 1 : 255;
      end
    end
    return m;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic tick();
    m4 = step(m4, resetn, sample_en, seg_in, 4);
    m1 = step(m1, resetn, sample_en, seg_in, 1);
    @(posedge clk);
    #1;
    chk("u4_value", 32'(v4), 32'(m4.value));
    chk("u4_valid", 32'(vl4), 32'(m4.valid));
    chk("u4_blank", 32'(bl4), 32'(m4.blank));
    chk("u4_new_value", 32'(nv4), 32'(m4.nv));
    chk("u4_err", 32'(er4), 32'(m4.err));
    chk("u4_err_count", 32'(ec4), 32'(m4.errc));
    chk("u1_value", 32'(v1), 32'(m1.value));
    chk("u1_valid", 32'(vl1), 32'(m1.valid));
    chk("u1_blank", 32'(bl1), 32'(m1.blank));
    chk("u1_new_value", 32'(nv1), 32'(m1.nv));
    chk("u1_err", 32'(er1), 32'(m1.err));
    chk("u1_err_count", 32'(ec1), 32'(m1.errc));
  endtask

  typedef struct {
    bit rst_n;
    bit en;
    logic [6:0] seg;
    logic [3:0] value;
    bit valid, blank, nv, err;
    logic [7:0] errc;
  } vec_t;

  vec_t vecs [$];
  int pulses;

  initial begin
    // reset, 30 held: accept after edge 4
    vecs.push_back('{0, 1, 7'h30, 4'h0, 0, 0, 0, 0, 8'd0});
    vecs.push_back('{1, 1, 7'h30, 4'h0, 0, 0, 0, 0, 8'd0});
    vecs.push_back('{1, 1, 7'h30, 4'h0, 0, 0, 0, 0, 8'd0});
    vecs.push_back('{1, 1, 7'h30, 4'h0, 0, 0, 0, 0, 8'd0});
    vecs.push_back('{1, 1, 7'h30, 4'h3, 1, 0, 1, 0, 8'd0});
    vecs.push_back('{1, 1, 7'h30, 4'h3, 1, 0, 0, 0, 8'd0});
    // 7F held -> blank, then 55 -> one err
    for (int i = 0; i < 3; i++) vecs.push_back('{1, 1, 7'h7F, 4'h3, 0, 0, 0, 0, 8'd0});
    vecs.push_back('{1, 1, 7'h7F, 4'h3, 0, 1, 0, 0, 8'd0});
    vecs.push_back('{1, 1, 7'h7F, 4'h3, 0, 1, 0, 0, 8'd0});
    for (int i = 0; i < 3; i++) vecs.push_back('{1, 1, 7'h55, 4'h3, 0, 0, 0, 0, 8'd0});
    vecs.push_back('{1, 1, 7'h55, 4'h3, 0, 0, 0, 1, 8'd1});
    vecs.push_back('{1, 1, 7'h55, 4'h3, 0, 0, 0, 0, 8'd1});
    // 79 twice then 24 restarts counting
    vecs.push_back('{1, 1, 7'h79, 4'h3, 0, 0, 0, 0, 8'd1});
    vecs.push_back('{1, 1, 7'h79, 4'h3, 0, 0, 0, 0, 8'd1});
    for (int i = 0; i < 3; i++) vecs.push_back('{1, 1, 7'h24, 4'h3, 0, 0, 0, 0, 8'd1});
    vecs.push_back('{1, 1, 7'h24, 4'h2, 1, 0, 1, 0, 8'd1});
    // 12 with sample_en toggling: accept on 4th enabled edge
    for (int i = 0; i < 6; i++)
      vecs.push_back('{1, (i % 2 == 0), 7'h12, 4'h2, 0, 0, 0, 0, 8'd1});
    vecs.push_back('{1, 1, 7'h12, 4'h5, 1, 0, 1, 0, 8'd1});
    vecs.push_back('{1, 0, 7'h12, 4'h5, 1, 0, 0, 0, 8'd1});
    vecs.push_back('{1, 1, 7'h12, 4'h5, 1, 0, 0, 0, 8'd1});

    foreach (vecs[i]) begin
      resetn = vecs[i].rst_n;
      sample_en = vecs[i].en;
      seg_in = vecs[i].seg;
      tick();
      chk($sformatf("vec%0d_value", i), 32'(v4), 32'(vecs[i].value));
      chk($sformatf("vec%0d_valid", i), 32'(vl4), 32'(vecs[i].valid));
      chk($sformatf("vec%0d_blank", i), 32'(bl4), 32'(vecs[i].blank));
      chk($sformatf("vec%0d_new_value", i), 32'(nv4), 32'(vecs[i].nv));
      chk($sformatf("vec%0d_err", i), 32'(er4), 32'(vecs[i].err));
      chk($sformatf("vec%0d_err_count", i), 32'(ec4), 32'(vecs[i].errc));
    end

    // reset in LOCKED, then 7F treated as a fresh pattern
    resetn = 0;
    tick();
    resetn = 1;
    seg_in = 7'h7F;
    sample_en = 1;
    repeat (4) tick();
    chk("reset_then_blank", 32'(bl4), 32'd1);
    chk("reset_then_blank_u1", 32'(bl1), 32'd1);

    // sweep all legal glyphs
    resetn = 0;
    tick();
    resetn = 1;
    pulses = 0;
    for (int d = 0; d < 16; d++) begin
      seg_in = codes[d];
      for (int k = 0; k < 6; k++) begin
        tick();
        if (nv4) pulses++;
      end
      chk($sformatf("sweep_value_%0d", d), 32'(v4), 32'(d));
    end
    chk("sweep_pulses", 32'(pulses), 32'd16);
    chk("sweep_err_count", 32'(ec4), 32'd0);

    // err_count saturation
    for (int k = 0; k < 300; k++) begin
      seg_in = (k % 2) ? 7'h2A : 7'h55;
      repeat (4) tick();
    end
    chk("sat_err_count", 32'(ec4), 32'd255);
    chk("sat_err_count_u1", 32'(ec1), 32'd255);
    resetn = 0;
    tick();
    chk("sat_reset_err_count", 32'(ec4), 32'd0);
    resetn = 1;

    // randomized traffic
    for (int s = 0; s < 600; s++) begin
      int r;
      r = $urandom_range(0, 9);
      seg_in = (r < 6) ? codes[$urandom_range(0, 15)] : (r < 8) ? 7'h7F : 7'($urandom);
      repeat ($urandom_range(1, 7)) begin
        sample_en = ($urandom_range(0, 3) != 0);
        resetn = ($urandom_range(0, 99) != 0);
        tick();
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
